// File: rtl/exibe_sequencia.sv
// Sequence presenter: on iniciar, lights ROM moves 0..limite for T_ACESO cycles each with T_APAGADO dark gaps, then pulses pronto.
// Optional EXIBE_CANCELA_EN adds a cancelar input that aborts a presentation back to idle.
module exibe_sequencia #(
    parameter int T_ACESO   = 1000,
    parameter int T_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
`ifdef EXIBE_CANCELA_EN
    input  logic       cancelar,
`endif
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TW-1:0] ACESO_FIM   = TW'(T_ACESO - 1);
    localparam logic [TW-1:0] APAGADO_FIM = TW'(T_APAGADO - 1);

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        CARREGA = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [3:0]    endereco_q, endereco_d;
    logic [3:0]    lim_q, lim_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    leds_q, leds_d;
    logic          ocupado_q, ocupado_d;
    logic          pronto_q, pronto_d;

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        lim_d      = lim_q;
        timer_d    = timer_q;
        leds_d     = leds_q;
        pronto_d   = 1'b0;

        case (estado_q)
            INICIAL: begin
                leds_d = 4'd0;
                if (iniciar) begin
                    endereco_d = 4'd0;
                    lim_d      = limite;
                    timer_d    = '0;
                    estado_d   = CARREGA;
                end
            end
            CARREGA: begin
                leds_d   = dado;
                timer_d  = '0;
                estado_d = ACESO;
            end
            ACESO: begin
                if (timer_q == ACESO_FIM) begin
                    leds_d   = 4'd0;
                    timer_d  = '0;
                    estado_d = APAGADO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            APAGADO: begin
                if (timer_q == APAGADO_FIM) begin
                    timer_d = '0;
                    // pronto is registered so it lines up with the FIM cycle itself
                    if (endereco_q == lim_q) begin
                        estado_d = FIM;
                        pronto_d = 1'b1;
                    end else begin
                        estado_d = PROXIMO;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PROXIMO: begin
                endereco_d = endereco_q + 1'b1;
                estado_d   = CARREGA;
            end
            FIM: begin
                estado_d = INICIAL;
            end
            default: begin
                leds_d   = 4'd0;
                estado_d = INICIAL;
            end
        endcase

`ifdef EXIBE_CANCELA_EN
        if (cancelar && (estado_q != INICIAL)) begin
            estado_d   = INICIAL;
            leds_d     = 4'd0;
            endereco_d = 4'd0;
            timer_d    = '0;
            pronto_d   = 1'b0;
        end
`endif

        ocupado_d = (estado_d != INICIAL);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            endereco_q <= 4'd0;
            lim_q      <= 4'd0;
            timer_q    <= '0;
            leds_q     <= 4'd0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            lim_q      <= lim_d;
            timer_q    <= timer_d;
            leds_q     <= leds_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
        end
    end

    assign endereco  = endereco_q;
    assign leds      = leds_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = {1'b0, estado_q};

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed scenarios with random ROM contents and random limite noise, checked cycle by cycle against a timeline model.
module tb_exibe_sequencia;
    localparam int TA = 4;
    localparam int TP = 2;
    localparam int P  = TA + TP + 2;
    localparam int NEVER = 1 << 30;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] limite  = 4'd0;
    logic [3:0] dado, endereco, leds, db_estado;
    logic       ocupado, pronto;
`ifdef EXIBE_CANCELA_EN
    logic       cancelar = 1'b0;
`endif
    logic [3:0] rom [16];

    int checks   = 0;
    int failures = 0;
    int idle_end = 0;

    always #5 clock = ~clock;

    assign dado = rom[endereco];

    exibe_sequencia #(.T_ACESO(TA), .T_APAGADO(TP)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
`ifdef EXIBE_CANCELA_EN
        .cancelar  (cancelar),
`endif
        .limite    (limite),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    task automatic check(input string tag, input logic [13:0] exp_v);
        logic [13:0] obs;
        obs = {leds, endereco, ocupado, pronto, db_estado};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed{leds,end,ocup,pronto,est}=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Expected outputs in cycle c of a run of n moves started in cycle 0,
    // optionally aborted (reset/cancel sampled) at the end of cycle abort_c.
    function automatic logic [13:0] model(input int c, input int n, input int abort_c);
        int k, r;
        logic [3:0] st, l;
        if (c > abort_c) return 14'd0;
        if (c > n * P) return {4'd0, 4'(n - 1), 2'b00, 4'd0};
        k = (c - 1) / P;
        r = (c - 1) % P;
        l = (r >= 1 && r <= TA) ? rom[k] : 4'd0;
        if (r == 0)            st = 4'd1;
        else if (r <= TA)      st = 4'd2;
        else if (r <= TA + TP) st = 4'd3;
        else                   st = (k == n - 1) ? 4'd5 : 4'd4;
        return {l, 4'(k), 1'b1, 1'(c == n * P), st};
    endfunction

    task automatic run(input int lim, input int retrig, input bit lim7,
                       input int rst_at, input int cancel_at);
        int n, abort_c, last;
        n = lim + 1;
        for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
        abort_c = (rst_at > 0) ? rst_at : ((cancel_at > 0) ? cancel_at : NEVER);
        last    = (abort_c < n * P) ? abort_c + 3 : n * P + 2;

        check($sformatf("idle_before lim=%0d", lim), {4'd0, 4'(idle_end), 6'd0});
        limite  = 4'(lim);
        iniciar = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(posedge clock);
            #1;
            check($sformatf("lim=%0d rt=%0d rst=%0d can=%0d c=%0d", lim, retrig, rst_at, cancel_at, c),
                  model(c, n, abort_c));
            iniciar = (c == retrig);
            limite  = (lim7 && c == 3) ? 4'd7 : 4'($urandom);
            reset   = !(c == rst_at);
`ifdef EXIBE_CANCELA_EN
            cancelar = (c == cancel_at);
`endif
        end
        iniciar = 1'b0;
        reset   = 1'b1;
`ifdef EXIBE_CANCELA_EN
        cancelar = 1'b0;
`endif
        idle_end = (abort_c < n * P) ? 0 : lim;
    endtask

    initial begin
        int l;
        for (int i = 0; i < 16; i++) rom[i] = 4'd0;
        reset   = 1'b0;
        iniciar = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 14'd0);
        iniciar = 1'b0;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        check("idle_after_reset", 14'd0);

        run(0, 0, 1'b0, 0, 0);
        run(2, 0, 1'b0, 0, 0);
        run(1, 5, 1'b0, 0, 0);
        run(1, 5, 1'b1, 0, 0);
        run(1, 2 * P, 1'b0, 0, 0);
        run(2, 0, 1'b0, 3, 0);
        run(3, 0, 1'b0, 0, 0);
        run(15, 0, 1'b0, 0, 0);
`ifdef EXIBE_CANCELA_EN
        run(2, 0, 1'b0, 0, 11);
        run(1, 0, 1'b0, 0, 0);
`endif
        repeat (5) begin
            l = $urandom_range(0, 5);
            run(l, $urandom_range(1, (l + 1) * P), 1'b0, 0, 0);
        end
        l = $urandom_range(1, 4);
        run(l, 0, 1'b0, $urandom_range(1, (l + 1) * P - 1), 0);
        run(0, 0, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
